// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment lookup for the multiplexed display.
// Segment order is {g,f,e,d,c,b,a}; every pattern is active-low.
package seven_seg_pkg;

  typedef logic [2:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Index = nibble value; entries show 0-9, A, b, C, d, E, F.
  localparam seg_t SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble-to-segment decoder built on the package lookup table.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Eight-digit common-anode scanner: latches a 32-bit value on load and
// shows one hex digit per refresh tick on active-low anode/cathode pins.
// Optional leading-zero blanking is built when SEVENSEG_LZB_EN is defined.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int DIGIT_HZ   = 1000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        enable,
  output logic [7:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp
);

  localparam int                TICK_DIV   = CLK_HZ / DIGIT_HZ;
  localparam int                CNT_W      = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam digit_idx_t        DIGIT_LAST = digit_idx_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  digit_idx_t       digit_idx_q, digit_idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       anode_q, anode_d;
  seg_t             cathode_q, cathode_d;

  logic             tick;
  logic [3:0]       nibble;
  seg_t             seg_pat;
  logic [7:0]       blank_vec;

  assign tick   = (tick_cnt_q == TICK_LAST);
  assign nibble = shadow_q[{digit_idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble),
    .seg_o    (seg_pat)
  );

`ifdef SEVENSEG_LZB_EN
  // zero_above[i] is set when nibbles i..NUM_DIGITS-1 of the shadow are all 0.
  logic [NUM_DIGITS:0] zero_above;
  assign zero_above[NUM_DIGITS] = 1'b1;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lzb
    if (gi >= NUM_DIGITS) begin : g_unused
      assign blank_vec[gi] = 1'b0;
    end else if (gi == 0) begin : g_digit0
      // Digit 0 always shows, so a zero value displays a single "0".
      assign zero_above[gi] = zero_above[gi+1] & (shadow_q[4*gi +: 4] == 4'h0);
      assign blank_vec[gi]  = 1'b0;
    end else begin : g_upper
      assign zero_above[gi] = zero_above[gi+1] & (shadow_q[4*gi +: 4] == 4'h0);
      assign blank_vec[gi]  = zero_above[gi];
    end
  end
`else
  assign blank_vec = 8'h00;
`endif

  // Next-state for the tick divider, scan index, shadow and output register.
  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + CNT_W'(1);
    digit_idx_d = digit_idx_q;
    if (tick) begin
      digit_idx_d = (digit_idx_q == DIGIT_LAST) ? '0 : digit_idx_q + digit_idx_t'(1);
    end
    shadow_d  = load ? value : shadow_q;
    // Outputs follow the index held this cycle, so they trail it by one clock.
    anode_d   = enable ? ~(8'b1 << digit_idx_q) : 8'hFF;
    cathode_d = (!enable || blank_vec[digit_idx_q]) ? SEG_BLANK : seg_pat;
  end

  // State and registered pin drivers; reset blanks the display immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      digit_idx_q <= '0;
      shadow_q    <= '0;
      anode_q     <= 8'hFF;
      cathode_q   <= SEG_BLANK;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      digit_idx_q <= digit_idx_d;
      shadow_q    <= shadow_d;
      anode_q     <= anode_d;
      cathode_q   <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;
  assign dp      = 1'b1;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: an 8-digit and a 4-digit instance share
// stimulus; expected pin values are queued as each cycle is driven and popped
// once the outputs for that cycle are visible. SEVENSEG_LZB_EN adds the
// leading-zero-blanking scenario.
module tb_seven_seg_scan;

  localparam int CLK_HZ   = 8;
  localparam int DIGIT_HZ = 2;
  localparam int TICK_DIV = CLK_HZ / DIGIT_HZ;

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] value  = 32'h0;
  logic        load   = 1'b0;
  logic        enable = 1'b1;
  logic [7:0]  anode,  anode4;
  logic [6:0]  cathode, cathode4;
  logic        dp, dp4;

  always #5 clock = ~clock;

  seven_seg_scan #(.CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ), .NUM_DIGITS(8)) dut8 (
    .clock(clock), .reset(reset), .value(value), .load(load), .enable(enable),
    .anode(anode), .cathode(cathode), .dp(dp)
  );

  seven_seg_scan #(.CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ), .NUM_DIGITS(4)) dut4 (
    .clock(clock), .reset(reset), .value(value), .load(load), .enable(enable),
    .anode(anode4), .cathode(cathode4), .dp(dp4)
  );

  typedef struct packed {
    logic [7:0] an8;
    logic [6:0] ca8;
    logic [7:0] an4;
    logic [6:0] ca4;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model state.
  int          m_tcnt;
  int          m_idx8;
  int          m_idx4;
  logic [31:0] m_shadow;

  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] ref_cathode(input int idx, input int ndig, input logic en);
    logic [3:0] nib;
    bit         blank;
    nib   = m_shadow[idx*4 +: 4];
    blank = 1'b0;
`ifdef SEVENSEG_LZB_EN
    if (idx != 0) begin
      blank = 1'b1;
      for (int k = idx; k < ndig; k++) begin
        if (m_shadow[k*4 +: 4] != 4'h0) blank = 1'b0;
      end
    end
`endif
    return (!en || blank) ? 7'h7F : seg_ref[nib];
  endfunction

  function automatic logic [7:0] ref_anode(input int idx, input logic en);
    logic [7:0] one_hot;
    one_hot = 8'h01 << idx;
    return en ? ~one_hot : 8'hFF;
  endfunction

  task automatic model_reset();
    m_tcnt   = 0;
    m_idx8   = 0;
    m_idx4   = 0;
    m_shadow = 32'h0;
  endtask

  // Drive one cycle of stimulus, queue the pin values it must produce, advance.
  task automatic drive(input logic ld, input logic [31:0] v, input logic en);
    exp_t e;
    load   = ld;
    value  = v;
    enable = en;
    e.an8 = ref_anode(m_idx8, en);
    e.ca8 = ref_cathode(m_idx8, 8, en);
    e.an4 = ref_anode(m_idx4, en);
    e.ca4 = ref_cathode(m_idx4, 4, en);
    sb.push_back(e);
    if (m_tcnt == TICK_DIV - 1) begin
      m_tcnt = 0;
      m_idx8 = (m_idx8 + 1) % 8;
      m_idx4 = (m_idx4 + 1) % 4;
    end else begin
      m_tcnt++;
    end
    if (ld) m_shadow = v;
    @(posedge clock);
    #1;
    cyc++;
    $display("cyc %0d ld=%0b en=%0b an8=%h ca8=%b an4=%h ca4=%b", cyc, ld, en,
             anode, cathode, anode4, cathode4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({anode, cathode, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_bad++;
      $display("FAIL reset8 got an=%h ca=%b dp=%b want an=ff ca=1111111 dp=1", anode, cathode, dp);
    end
    n_cmp++;
    if ({anode4, cathode4, dp4} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_bad++;
      $display("FAIL reset4 got an=%h ca=%b dp=%b want an=ff ca=1111111 dp=1", anode4, cathode4, dp4);
    end
    reset = 1'b0;
    model_reset();
    // First cycle after release: digit 0 of a zero shadow.
    drive(1'b0, 32'h0, 1'b1);
    void'(sb.pop_front());
    n_cmp++;
    if ({anode, cathode, dp} !== {8'hFE, 7'b1000000, 1'b1}) begin
      n_bad++;
      $display("FAIL first_digit got an=%h ca=%b dp=%b want an=fe ca=1000000 dp=1", anode, cathode, dp);
    end
  endtask

  task automatic test_walk();
    exp_t e;
    for (int i = 0; i < 36; i++) begin
      drive(i == 0, 32'h89ABCDEF, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if ({anode, cathode, dp} !== {e.an8, e.ca8, 1'b1}) begin
        n_bad++;
        $display("FAIL walk8 step %0d got an=%h ca=%b dp=%b want an=%h ca=%b", i, anode, cathode, dp, e.an8, e.ca8);
      end
      n_cmp++;
      if ({anode4, cathode4, dp4} !== {e.an4, e.ca4, 1'b1}) begin
        n_bad++;
        $display("FAIL walk4 step %0d got an=%h ca=%b want an=%h ca=%b", i, anode4, cathode4, e.an4, e.ca4);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 32'h12345678 + i, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if ({anode, cathode, anode4, cathode4} !== {e.an8, e.ca8, e.an4, e.ca4}) begin
        n_bad++;
        $display("FAIL hold step %0d got %h/%b %h/%b want %h/%b %h/%b", i, anode, cathode,
                 anode4, cathode4, e.an8, e.ca8, e.an4, e.ca4);
      end
    end
  endtask

  task automatic test_load_on_tick();
    exp_t e;
    int   guard;
    guard = 0;
    while (m_tcnt != TICK_DIV - 1 && guard < 8) begin
      drive(1'b0, 32'h0, 1'b1);
      void'(sb.pop_front());
      guard++;
    end
    n_cmp++;
    if (m_tcnt != TICK_DIV - 1) begin
      n_bad++;
      $display("FAIL tick_align got tcnt=%0d want %0d", m_tcnt, TICK_DIV - 1);
    end
    for (int i = 0; i < 36; i++) begin
      drive(i == 0, 32'h76543210, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if ({anode, cathode, dp, anode4, cathode4, dp4} !== {e.an8, e.ca8, 1'b1, e.an4, e.ca4, 1'b1}) begin
        n_bad++;
        $display("FAIL load_tick step %0d got %h/%b %h/%b want %h/%b %h/%b", i, anode, cathode,
                 anode4, cathode4, e.an8, e.ca8, e.an4, e.ca4);
      end
    end
  endtask

  task automatic test_enable();
    exp_t e;
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, 32'h0, i >= 10);
      e = sb.pop_front();
      n_cmp++;
      if ({anode, cathode, anode4, cathode4} !== {e.an8, e.ca8, e.an4, e.ca4}) begin
        n_bad++;
        $display("FAIL enable step %0d got %h/%b %h/%b want %h/%b %h/%b", i, anode, cathode,
                 anode4, cathode4, e.an8, e.ca8, e.an4, e.ca4);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({anode, cathode, dp, anode4, cathode4} !== {8'hFF, 7'h7F, 1'b1, 8'hFF, 7'h7F}) begin
      n_bad++;
      $display("FAIL reset_mid got %h/%b/%b %h/%b want ff/1111111/1 ff/1111111", anode, cathode, dp,
               anode4, cathode4);
    end
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'hFFFF_FFFF, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if ({anode, cathode, anode4, cathode4} !== {e.an8, e.ca8, e.an4, e.ca4}) begin
        n_bad++;
        $display("FAIL post_reset step %0d got %h/%b %h/%b want %h/%b %h/%b", i, anode, cathode,
                 anode4, cathode4, e.an8, e.ca8, e.an4, e.ca4);
      end
    end
  endtask

`ifdef SEVENSEG_LZB_EN
  task automatic test_lzb();
    exp_t e;
    for (int i = 0; i < 72; i++) begin
      drive(i == 0 || i == 36, (i < 36) ? 32'h00000305 : 32'h0, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if ({anode, cathode, anode4, cathode4} !== {e.an8, e.ca8, e.an4, e.ca4}) begin
        n_bad++;
        $display("FAIL lzb step %0d got %h/%b %h/%b want %h/%b %h/%b", i, anode, cathode,
                 anode4, cathode4, e.an8, e.ca8, e.an4, e.ca4);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_walk();
    test_hold();
    test_load_on_tick();
    test_enable();
    test_reset_mid();
`ifdef SEVENSEG_LZB_EN
    test_lzb();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
